dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that sits between the CPU's MEM stage and a line-wide, multi-cycle backing data memory. It serves single-word loads and stores from the EX_MEM pipeline register and holds the pipeline with `stall_o` on a miss. On a miss it evicts a dirty victim over a request/acknowledge memory handshake, then refills the line. It replaces the single-cycle data memory in the MEM stage.

---
 rtl/dcache_pkg.sv | 11 +
 rtl/dcache_array.sv | 55 +++++
 rtl/dcache_controller.sv | 94 +++++++++
 tb/tb_dcache_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM states, default geometry, address-field widths and line type for the data cache.
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WB, FILL, REFILL} state_t;
  localparam int DEF_NUM_LINES = 32;
  localparam int DEF_LINE_WORDS = 8;
  localparam int DEF_IDX_W = $clog2(DEF_NUM_LINES);
  localparam int DEF_WSEL_W = $clog2(DEF_LINE_WORDS);
  localparam int DEF_OFF_W = DEF_WSEL_W + 2;
  localparam int DEF_TAG_W = 32 - DEF_IDX_W - DEF_OFF_W;
  typedef logic [32*DEF_LINE_WORDS-1:0] line_t;
endpackage

// File: rtl/dcache_array.sv
// dcache_array: valid/dirty/tag/data storage for a direct-mapped cache.
// Ports: clk, rst_n (sync active-low, clears valid/dirty), idx selects the line read combinationally
// onto valid/dirty/tag/data; word_we writes word_data at word_sel, line_we writes line_data/line_tag
// and marks the line valid and clean.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int WSEL_W = $clog2(LINE_WORDS),
  localparam int TAG_W = 32 - IDX_W - WSEL_W - 2,
  localparam int LINE_W = 32 * LINE_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              word_we,
  input  logic [WSEL_W-1:0] word_sel,
  input  logic [31:0]       word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] data
);
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q [NUM_LINES];
  logic [LINE_W-1:0] data_q [NUM_LINES];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag = tag_q[idx];
  assign data = data_q[idx];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[idx] <= line_data;
      tag_q[idx] <= line_tag;
    end else if (word_we) begin
      data_q[idx][word_sel*32 +: 32] <= word_data;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache for the MEM stage.
// Ports: CPU side req_i/we_i/addr_i/wdata_i in, rdata_o/stall_o out; memory side line-wide
// mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o out, mem_rdata_i/mem_ack_i in; access and miss counters.
// clk_i rising edge, rst_i synchronous active-low.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  localparam int IDX_W = $clog2(NUM_LINES),
  localparam int WSEL_W = $clog2(LINE_WORDS),
  localparam int OFF_W = WSEL_W + 2,
  localparam int TAG_W = 32 - IDX_W - OFF_W,
  localparam int LINE_W = 32 * LINE_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic [31:0]       access_cnt_o,
  output logic [31:0]       miss_cnt_o
);
  state_t state, next;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag, line_tag;
  logic [WSEL_W-1:0] wsel;
  logic [LINE_W-1:0] line_data, fill_buf;
  logic line_valid, line_dirty, hit, miss;
  logic unused_low;
  assign unused_low = ^addr_i[1:0];
  assign idx = addr_i[OFF_W +: IDX_W];
  assign tag = addr_i[31 -: TAG_W];
  assign wsel = addr_i[2 +: WSEL_W];
  assign hit = line_valid & (line_tag == tag);
  assign miss = req_i & ~hit & (state == IDLE);
  assign stall_o = miss | (state != IDLE);
  assign rdata_o = line_data[wsel*32 +: 32];
  dcache_array #(.NUM_LINES(NUM_LINES), .LINE_WORDS(LINE_WORDS)) u_array (
    .clk(clk_i),
    .rst_n(rst_i),
    .idx(idx),
    .word_we(req_i & we_i & ~stall_o),
    .word_sel(wsel),
    .word_data(wdata_i),
    .line_we(state == REFILL),
    .line_tag(tag),
    .line_data(fill_buf),
    .valid(line_valid),
    .dirty(line_dirty),
    .tag(line_tag),
    .data(line_data)
  );
  always_comb begin
    next = state == IDLE ? (miss ? (line_valid & line_dirty ? WB : FILL) : IDLE)
         : state == WB   ? (mem_ack_i ? FILL : WB)
         : state == FILL ? (mem_ack_i ? REFILL : FILL)
         : IDLE;
  end
  // Memory-side outputs are registered from the next state so they appear the cycle the state is entered.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      mem_req_o <= 1'b0;
      mem_we_o <= 1'b0;
      mem_addr_o <= '0;
      mem_wdata_o <= '0;
      fill_buf <= '0;
      access_cnt_o <= '0;
      miss_cnt_o <= '0;
    end else begin
      state <= next;
      mem_req_o <= (next == WB) | (next == FILL);
      mem_we_o <= next == WB;
      if (state == IDLE && next == WB) begin
        mem_addr_o <= {line_tag, idx, {OFF_W{1'b0}}};
        mem_wdata_o <= line_data;
      end
      if (state != FILL && next == FILL) mem_addr_o <= {tag, idx, {OFF_W{1'b0}}};
      if (state == FILL && mem_ack_i) fill_buf <= mem_rdata_i;
      if (req_i & ~stall_o) access_cnt_o <= access_cnt_o + 32'd1;
      if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed and randomized checks of dcache_controller against a flat-memory reference model.
module tb_dcache_controller;
  import dcache_pkg::*;
  logic clk, rst_i, req_i, we_i, stall_o, mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] addr_i, wdata_i, rdata_o, mem_addr_o, access_cnt_o, miss_cnt_o;
  line_t mem_wdata_o, mem_rdata_i;
  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .access_cnt_o(access_cnt_o), .miss_cnt_o(miss_cnt_o)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  bit mv [32];
  bit md [32];
  logic [21:0] mt [32];
  int lat = 10, cnt = 0, checks = 0, passes = 0, fails = 0, exp_acc = 0, exp_miss = 0, st_last;
  logic [31:0] rd_last, last_wb_addr, last_fill_addr, first_addr;
  logic first_req, first_we;
  line_t last_wb_data;
  always @(negedge clk) begin
    if (mem_ack_i) begin
      mem_ack_i = 0;
      cnt = 0;
    end
    if (mem_req_o) begin
      cnt++;
      if (cnt == lat + 1) begin
        mem_ack_i = 1;
        if (mem_we_o) begin
          last_wb_addr = mem_addr_o;
          last_wb_data = mem_wdata_o;
          for (int k = 0; k < 8; k++) mem[int'(mem_addr_o[13:2]) + k] = mem_wdata_o[32*k +: 32];
        end else begin
          last_fill_addr = mem_addr_o;
          for (int k = 0; k < 8; k++) mem_rdata_i[32*k +: 32] = mem[int'(mem_addr_o[13:2]) + k];
        end
      end
    end else cnt = 0;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d, output int st, output logic [31:0] rd);
    bit done = 0;
    req_i = 1; we_i = w; addr_i = a; wdata_i = d;
    st = 0; rd = '0; first_req = 0; first_we = 0; first_addr = '0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (c == 1) begin
        first_req = mem_req_o;
        first_we = mem_we_o;
        first_addr = mem_addr_o;
      end
      if (!stall_o) begin
        rd = rdata_o;
        done = 1;
      end else st++;
    end
    check("access_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;
    req_i = 0; we_i = 0;
  endtask
  task automatic op(input logic w, input logic [31:0] a, input logic [31:0] d);
    int i = int'(a[9:5]);
    logic [21:0] t = a[31:10];
    bit hit = mv[i] && mt[i] == t;
    int exp_st = hit ? 0 : 3 + lat + ((mv[i] && md[i]) ? 1 + lat : 0);
    exp_acc++;
    if (!hit) exp_miss++;
    access(w, a, d, st_last, rd_last);
    check("stall_cycles", 64'(st_last), 64'(exp_st));
    if (!w) check("load_data", 64'(rd_last), 64'(ref_mem[a[13:2]]));
    else ref_mem[a[13:2]] = d;
    check("access_cnt", 64'(access_cnt_o), 64'(exp_acc));
    check("miss_cnt", 64'(miss_cnt_o), 64'(exp_miss));
    md[i] = hit ? (md[i] | w) : w;
    mv[i] = 1;
    mt[i] = t;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0; md[i] = 0; mt[i] = '0;
    end
    mem_ack_i = 0; mem_rdata_i = '0;
    rst_i = 0; req_i = 0; we_i = 0; addr_i = '0; wdata_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_we", 64'(mem_we_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_mem_wdata_or", 64'(|mem_wdata_o), 64'd0);
    check("rst_access_cnt", 64'(access_cnt_o), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt_o), 64'd0);
    rst_i = 1;
    op(0, 32'h40, 0);
    check("fill_req_rise", 64'(first_req), 64'd1);
    check("fill_addr", 64'(first_addr), 64'h40);
    check("fill_we", 64'(first_we), 64'd0);
    check("clean_miss_13", 64'(st_last), 64'd13);
    check("first_miss_cnt", 64'(miss_cnt_o), 64'd1);
    op(0, 32'h44, 0);
    check("hit_no_stall", 64'(st_last), 64'd0);
    check("hit_access_cnt", 64'(access_cnt_o), 64'd2);
    op(1, 32'h48, 32'hDEADBEEF);
    check("store_hit_stall", 64'(st_last), 64'd0);
    op(0, 32'h48, 0);
    check("load_after_store", 64'(rd_last), 64'hDEADBEEF);
    op(0, 32'h440, 0);
    check("dirty_miss_24", 64'(st_last), 64'd24);
    check("dirty_first_is_wb", 64'(first_we), 64'd1);
    check("wb_addr", 64'(last_wb_addr), 64'h40);
    check("wb_word2", 64'(last_wb_data[95:64]), 64'hDEADBEEF);
    check("refill_addr", 64'(last_fill_addr), 64'h440);
    check("dirty_miss_cnt", 64'(miss_cnt_o), 64'd2);
    op(1, 32'h800, 32'h12345678);
    check("store_miss_13", 64'(st_last), 64'd13);
    check("store_fill_addr", 64'(last_fill_addr), 64'h800);
    op(0, 32'h0, 0);
    check("evict_store_24", 64'(st_last), 64'd24);
    check("evict_wb_addr", 64'(last_wb_addr), 64'h800);
    check("evict_wb_word0", 64'(last_wb_data[31:0]), 64'h12345678);
    for (int n = 0; n < 250; n++) begin
      lat = $urandom_range(0, 4);
      op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 8191)), $urandom);
    end
    lat = 10;
    req_i = 1; we_i = 0; addr_i = 32'h2040;
    for (int c = 0; c < 100 && !(mem_req_o && !mem_we_o); c++) @(negedge clk);
    check("reached_fill", 64'(mem_req_o && !mem_we_o), 64'd1);
    rst_i = 0; req_i = 0;
    @(posedge clk);
    #1;
    check("abort_mem_req", 64'(mem_req_o), 64'd0);
    check("abort_idle", 64'(stall_o), 64'd0);
    check("abort_access_cnt", 64'(access_cnt_o), 64'd0);
    check("abort_miss_cnt", 64'(miss_cnt_o), 64'd0);
    rst_i = 1;
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0; md[i] = 0;
    end
    exp_acc = 0; exp_miss = 0;
    op(0, 32'h2040, 0);
    check("remiss_stall", 64'(st_last), 64'd13);
    check("remiss_cnt", 64'(miss_cnt_o), 64'd1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
